axi_row_receiver: RTL and testbench
===================================

Name: axi_row_receiver

Overview:
- Consumes the row-data stream that the ECD-Master returns for each row-request issued by the row-request generator.
- Frames the stream into rows of fixed beat count and forwards the beats downstream through a registered skid slice.
- Pulses row_complete once per terminated row; this output drives the request generator's row_complete_in flow control.
- Keeps row and framing-error statistics for software.

Parameters:
- BEATS_PER_ROW, 64, number of 256-bit beats in one complete row (legal range 2..4096).
- DW, 256, stream data width in bits.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- clear  in  1  one-cycle pulse; zeroes statistics (and the expected row number when the optional feature is compiled in).
- AXIS_RX_TDATA  in  DW  row data from ECD-Master.
- AXIS_RX_TVALID  in  1  upstream valid.
- AXIS_RX_TLAST  in  1  upstream end-of-row marker.
- AXIS_RX_TREADY  out  1  ready to upstream; registered.
- AXIS_TX_TDATA  out  DW  forwarded data; registered.
- AXIS_TX_TVALID  out  1  downstream valid.
- AXIS_TX_TLAST  out  1  downstream end-of-row marker.
- AXIS_TX_TREADY  in  1  downstream ready.
- row_complete  out  1  one-cycle pulse per terminated row.
- busy  out  1  high while a row is partially received.
- rows_received  out  32  count of terminated rows; wraps.
- short_errs  out  16  count of rows ended early by TLAST; saturates at 0xFFFF.
- long_errs  out  16  count of rows that reached BEATS_PER_ROW beats without TLAST; saturates at 0xFFFF.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - AXIS_RX_TREADY=0, AXIS_TX_TVALID=0, AXIS_TX_TLAST=0, row_complete=0, busy=0, all counters 0, skid buffer empty, beat counter 0, state RECV.
  - AXIS_RX_TREADY rises to 1 on the first cycle after reset releases.
  - Reset asserted mid-row discards the partial row and any skid contents. It produces no row_complete and no error count.
- Skid slice:
  - Two entries (output register plus skid register).
  - A beat is accepted when AXIS_RX_TVALID & AXIS_RX_TREADY.
  - Accepted beat appears on AXIS_TX one cycle later, minimum latency 1.
  - AXIS_RX_TREADY is low exactly when the skid register is occupied.
  - Full throughput of one beat per cycle while AXIS_TX_TREADY=1.
  - Ordering is preserved; beats are never duplicated or lost except when dropped in DRAIN.
- Beat counter: width clog2(BEATS_PER_ROW+1). Increments on every accepted beat in RECV.
- State RECV (accepted beat is beat n, 1-based):
  - TLAST=1 and n==BEATS_PER_ROW: good row. Forward with TLAST=1, counter to 0, row terminated.
  - TLAST=1 and n<BEATS_PER_ROW: short row. Forward with TLAST=1, short_errs+1, counter to 0, row terminated.
  - TLAST=0 and n==BEATS_PER_ROW: long row. Forward with AXIS_TX_TLAST forced to 1, long_errs+1, counter to 0, row terminated, go to DRAIN.
  - Otherwise: forward unchanged.
- State DRAIN:
  - Accepted beats are consumed and not forwarded; AXIS_RX_TREADY stays governed by the skid rule.
  - The beat with TLAST=1 returns the block to RECV. No second row_complete and no second error count.
- Row termination effects:
  - row_complete=1 on the cycle after the terminating beat is accepted, for exactly one cycle.
  - rows_received+1 on that same edge.
  - Errored rows still pulse row_complete so the upstream outstanding-request count stays correct.
- busy = (beat counter != 0) | (state == DRAIN).
- clear:
  - Zeroes rows_received, short_errs and long_errs. Does not disturb framing, state or the skid slice.
  - If clear coincides with a counter increment, clear wins and the counter reads 0 afterwards.
- Saturation: short_errs and long_errs hold at 0xFFFF. rows_received wraps 0xFFFFFFFF to 0.

Optional Feature:
- Macro: ROW_SEQ_CHECK_EN.
- With the macro defined:
  - Adds output seq_errs (16-bit, saturating) and an internal 32-bit expected-row register.
  - The expected-row register resets to 0x0000C008 and is reloaded to that value by clear.
  - On the first beat of each row, TDATA[39:8] is compared with the expected row.
  - Mismatch: seq_errs+1.
  - Either way, the expected row becomes TDATA[39:8]+1, which resynchronises after a mismatch.
  - clear zeroes seq_errs.
- Without the macro: no seq_errs port and no comparison logic.

Test Plan:
- Reset, then 3 rows of 64 beats with TLAST on beat 64 and TX_TREADY=1 -> 192 beats out in order at 1 beat/cycle, 3 row_complete pulses, rows_received=3, both error counters 0.
- Row with TLAST on beat 10 -> 10 beats forwarded, TX_TLAST on beat 10, short_errs=1, one row_complete; the next 64-beat row is clean.
- 70-beat row with TLAST on beat 70 -> beats 1-64 forwarded, TX_TLAST forced on beat 64, beats 65-70 dropped, long_errs=1, exactly one row_complete.
- TX_TREADY toggled with a random 50% duty cycle over 4 rows -> no beat lost or duplicated, RX_TREADY drops only when the skid register is full, data matches a scoreboard.
- Reset asserted at beat 30, then a full row -> no row_complete for the partial row, one for the full row, rows_received=1; clear coinciding with the row_complete cycle -> rows_received=0.
- ROW_SEQ_CHECK_EN defined: row headers 0xC008, 0xC009, 0xC00B, 0xC00C -> seq_errs=1 after row 3 and unchanged after row 4.

Source files
------------

// File: rtl/axi_row_receiver.sv
// Frames the ECD-Master row stream into BEATS_PER_ROW-beat rows, forwards beats through a
// two-entry skid slice and keeps row statistics. Optional row-number check: ROW_SEQ_CHECK_EN.
module axi_row_receiver #(
  parameter int unsigned BEATS_PER_ROW = 64,
  parameter int unsigned DW            = 256
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clear,
  input  logic [DW-1:0] AXIS_RX_TDATA,
  input  logic          AXIS_RX_TVALID,
  input  logic          AXIS_RX_TLAST,
  output logic          AXIS_RX_TREADY,
  output logic [DW-1:0] AXIS_TX_TDATA,
  output logic          AXIS_TX_TVALID,
  output logic          AXIS_TX_TLAST,
  input  logic          AXIS_TX_TREADY,
  output logic          row_complete,
  output logic          busy,
  output logic [31:0]   rows_received,
  output logic [15:0]   short_errs,
  output logic [15:0]   long_errs
`ifdef ROW_SEQ_CHECK_EN
  ,
  output logic [15:0]   seq_errs
`endif
);

  localparam int unsigned    CW       = $clog2(BEATS_PER_ROW + 1);
  localparam logic [CW-1:0]  LAST_CNT = CW'(BEATS_PER_ROW - 1);

  typedef enum logic {RECV, DRAIN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic          accept;
  logic          row_full;
  logic          push;
  logic          push_last;
  logic          row_end;
  logic          out_free;

  logic [DW-1:0] sk_data;
  logic          sk_valid;
  logic          sk_last;

  assign accept    = AXIS_RX_TVALID & AXIS_RX_TREADY;
  assign row_full  = (cnt == LAST_CNT);
  assign push      = accept & (state == RECV);
  assign push_last = AXIS_RX_TLAST | row_full;
  assign row_end   = push & push_last;
  assign out_free  = ~AXIS_TX_TVALID | AXIS_TX_TREADY;
  assign busy      = (cnt != '0) | (state == DRAIN);

  // Framing FSM: beat counter, RECV/DRAIN state and the row_complete pulse.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= RECV;
      cnt          <= '0;
      row_complete <= 1'b0;
    end else begin
      row_complete <= row_end;
      if (accept) begin
        unique case (state)
          RECV: begin
            if (push_last) begin
              cnt <= '0;
              if (!AXIS_RX_TLAST) state <= DRAIN;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DRAIN: if (AXIS_RX_TLAST) state <= RECV;
        endcase
      end
    end
  end

  // Skid slice. RX ready is registered as the inverse of the next skid occupancy,
  // so a push can only arrive while the skid register is empty.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      AXIS_TX_TVALID <= 1'b0;
      AXIS_TX_TLAST  <= 1'b0;
      sk_valid       <= 1'b0;
      sk_last        <= 1'b0;
      AXIS_RX_TREADY <= 1'b0;
    end else if (sk_valid) begin
      if (out_free) begin
        AXIS_TX_TDATA  <= sk_data;
        AXIS_TX_TLAST  <= sk_last;
        AXIS_TX_TVALID <= 1'b1;
        sk_valid       <= 1'b0;
        AXIS_RX_TREADY <= 1'b1;
      end
    end else if (out_free) begin
      AXIS_TX_TVALID <= push;
      AXIS_TX_TLAST  <= push & push_last;
      if (push) AXIS_TX_TDATA <= AXIS_RX_TDATA;
      AXIS_RX_TREADY <= 1'b1;
    end else if (push) begin
      sk_data        <= AXIS_RX_TDATA;
      sk_last        <= push_last;
      sk_valid       <= 1'b1;
      AXIS_RX_TREADY <= 1'b0;
    end else begin
      AXIS_RX_TREADY <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      rows_received <= '0;
      short_errs    <= '0;
      long_errs     <= '0;
    end else if (row_end) begin
      rows_received <= rows_received + 32'd1;
      if (AXIS_RX_TLAST && !row_full && short_errs != '1) short_errs <= short_errs + 16'd1;
      if (!AXIS_RX_TLAST && long_errs != '1)               long_errs  <= long_errs + 16'd1;
    end
  end

`ifdef ROW_SEQ_CHECK_EN
  localparam logic [31:0] SEQ_INIT = 32'h0000_C008;

  logic [31:0] exp_row;
  logic        first_beat;

  assign first_beat = push & (cnt == '0);

  // Expected row always follows the last header seen, so one gap costs one error.
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      exp_row  <= SEQ_INIT;
      seq_errs <= '0;
    end else if (first_beat) begin
      if (AXIS_RX_TDATA[39:8] != exp_row && seq_errs != '1) seq_errs <= seq_errs + 16'd1;
      exp_row <= AXIS_RX_TDATA[39:8] + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_row_receiver.sv
// Bench for axi_row_receiver: table of row shapes with hand-computed totals, randomized rows
// checked against a row-level queue model, plus reset and clear corner sequences.
`timescale 1ns/1ps
module tb_axi_row_receiver;

  localparam int unsigned B  = 64;
  localparam int unsigned DW = 256;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          clear = 1'b0;
  logic [DW-1:0] AXIS_RX_TDATA = '0;
  logic          AXIS_RX_TVALID = 1'b0;
  logic          AXIS_RX_TLAST = 1'b0;
  logic          AXIS_RX_TREADY;
  logic [DW-1:0] AXIS_TX_TDATA;
  logic          AXIS_TX_TVALID;
  logic          AXIS_TX_TLAST;
  logic          AXIS_TX_TREADY = 1'b1;
  logic          row_complete;
  logic          busy;
  logic [31:0]   rows_received;
  logic [15:0]   short_errs;
  logic [15:0]   long_errs;
`ifdef ROW_SEQ_CHECK_EN
  logic [15:0]   seq_errs;
`endif

  always #5 clk = ~clk;

  axi_row_receiver #(.BEATS_PER_ROW(B), .DW(DW)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .clear         (clear),
    .AXIS_RX_TDATA (AXIS_RX_TDATA),
    .AXIS_RX_TVALID(AXIS_RX_TVALID),
    .AXIS_RX_TLAST (AXIS_RX_TLAST),
    .AXIS_RX_TREADY(AXIS_RX_TREADY),
    .AXIS_TX_TDATA (AXIS_TX_TDATA),
    .AXIS_TX_TVALID(AXIS_TX_TVALID),
    .AXIS_TX_TLAST (AXIS_TX_TLAST),
    .AXIS_TX_TREADY(AXIS_TX_TREADY),
    .row_complete  (row_complete),
    .busy          (busy),
    .rows_received (rows_received),
    .short_errs    (short_errs),
`ifdef ROW_SEQ_CHECK_EN
    .seq_errs      (seq_errs),
`endif
    .long_errs     (long_errs)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Row-level reference: a row of len beats emits min(len,B) beats, the last one flagged.
  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] row_buf [0:255];
  int unsigned   exp_rows, exp_short, exp_long;

  function automatic void model_row(input int unsigned len);
    int unsigned kept;
    beat_t       b;
    kept = (len < B) ? len : B;
    for (int unsigned i = 0; i < kept; i++) begin
      b.last = (i == kept - 1);
      b.data = row_buf[i];
      exp_q.push_back(b);
    end
    exp_rows++;
    if (len < B) exp_short++;
    else if (len > B) exp_long++;
  endfunction

  task automatic fill_row(input int unsigned len);
    for (int unsigned i = 0; i < len; i++)
      for (int unsigned w = 0; w < DW / 32; w++)
        row_buf[i][w*32 +: 32] = $urandom;
  endtask

  // Monitor: output beats against the model, RX ready against the stall history.
  bit          mon_en = 1'b0;
  bit          prev_stall = 1'b0;
  int unsigned fwd_cnt = 0;
  int unsigned rc_cnt = 0;
  beat_t       mon_e;

  always @(negedge clk) begin
    if (mon_en) begin
      if (AXIS_TX_TVALID && AXIS_TX_TREADY) begin
        fwd_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_tx_beat", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("tx_data", AXIS_TX_TDATA, mon_e.data);
          check("tx_last", AXIS_TX_TLAST, mon_e.last);
        end
      end
      if (!AXIS_RX_TREADY) check("rx_ready_low_without_stall", prev_stall, 1);
      prev_stall = AXIS_TX_TVALID && !AXIS_TX_TREADY;
    end else begin
      prev_stall = 1'b0;
    end
  end

  always @(negedge clk) if (resetn && row_complete) rc_cnt++;

  bit rnd_ready = 1'b0;
  always @(posedge clk) #1 AXIS_TX_TREADY = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;

  int unsigned stall_cycles;

  // Sends beats 0..n_send-1 of row_buf; TLAST on beat len-1; optional clear on that beat.
  task automatic send_row(input int unsigned len, input int unsigned n_send, input bit clr_last);
    bit          acc;
    int unsigned guard;
    for (int unsigned i = 0; i < n_send; i++) begin
      AXIS_RX_TDATA  = row_buf[i];
      AXIS_RX_TVALID = 1'b1;
      AXIS_RX_TLAST  = (i == len - 1);
      clear          = clr_last && (i == len - 1);
      guard = 0;
      do begin
        @(negedge clk);
        acc = AXIS_RX_TREADY;
        if (!acc) stall_cycles++;
        @(posedge clk); #1;
        guard++;
      end while (!acc && guard < 1000);
      if (!acc) check("rx_accept_timeout", 0, 1);
    end
    AXIS_RX_TVALID = 1'b0;
    AXIS_RX_TLAST  = 1'b0;
    clear          = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    AXIS_RX_TVALID = 1'b0;
    AXIS_RX_TLAST  = 1'b0;
    resetn = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("rst_rx_ready", AXIS_RX_TREADY, 0);
    check("rst_tx_valid", AXIS_TX_TVALID, 0);
    check("rst_tx_last", AXIS_TX_TLAST, 0);
    check("rst_row_complete", row_complete, 0);
    check("rst_busy", busy, 0);
    check("rst_rows", rows_received, 0);
    check("rst_short", short_errs, 0);
    check("rst_long", long_errs, 0);
    resetn = 1'b1;
    @(posedge clk); #1;
    check("rx_ready_after_reset", AXIS_RX_TREADY, 1);
    exp_q.delete();
    exp_rows = 0; exp_short = 0; exp_long = 0;
    mon_en = 1'b1;
  endtask

  typedef struct {
    int unsigned len;
    bit          rnd;
    int unsigned exp_fwd;
    int unsigned exp_short;
    int unsigned exp_long;
    int unsigned exp_rows;
  } vec_t;

  vec_t        tbl[14];
  int unsigned fwd0, rc0, len;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // len, random TX ready, beats forwarded, cumulative short/long/rows afterwards
    tbl[0]  = '{64,  1'b0, 64, 0, 0, 1};
    tbl[1]  = '{64,  1'b0, 64, 0, 0, 2};
    tbl[2]  = '{64,  1'b0, 64, 0, 0, 3};
    tbl[3]  = '{10,  1'b0, 10, 1, 0, 4};
    tbl[4]  = '{64,  1'b0, 64, 1, 0, 5};
    tbl[5]  = '{70,  1'b0, 64, 1, 1, 6};
    tbl[6]  = '{64,  1'b0, 64, 1, 1, 7};
    tbl[7]  = '{1,   1'b0, 1,  2, 1, 8};
    tbl[8]  = '{128, 1'b0, 64, 2, 2, 9};
    tbl[9]  = '{64,  1'b1, 64, 2, 2, 10};
    tbl[10] = '{64,  1'b1, 64, 2, 2, 11};
    tbl[11] = '{63,  1'b1, 63, 3, 2, 12};
    tbl[12] = '{65,  1'b1, 64, 3, 3, 13};
    tbl[13] = '{64,  1'b1, 64, 3, 3, 14};

    do_reset();

    foreach (tbl[k]) begin
      rnd_ready = tbl[k].rnd;
      fwd0 = fwd_cnt; rc0 = rc_cnt; stall_cycles = 0;
      fill_row(tbl[k].len);
      model_row(tbl[k].len);
      send_row(tbl[k].len, tbl[k].len, 1'b0);
      wait_drain();
      check($sformatf("row%0d_fwd_beats", k), fwd_cnt - fwd0, tbl[k].exp_fwd);
      check($sformatf("row%0d_row_complete", k), rc_cnt - rc0, 1);
      check($sformatf("row%0d_rows", k), rows_received, tbl[k].exp_rows);
      check($sformatf("row%0d_short", k), short_errs, tbl[k].exp_short);
      check($sformatf("row%0d_long", k), long_errs, tbl[k].exp_long);
      check($sformatf("row%0d_busy_idle", k), busy, 0);
      if (!tbl[k].rnd) check($sformatf("row%0d_rx_stalls", k), stall_cycles, 0);
    end

    // Randomized back-to-back rows under random TX ready.
    rnd_ready = 1'b1;
    rc0 = rc_cnt;
    for (int unsigned r = 0; r < 12; r++) begin
      len = ($urandom_range(0, 9) < 6) ? B : $urandom_range(1, B + 20);
      fill_row(len);
      model_row(len);
      send_row(len, len, 1'b0);
    end
    wait_drain();
    check("rand_rows", rows_received, exp_rows);
    check("rand_short", short_errs, exp_short);
    check("rand_long", long_errs, exp_long);
    check("rand_row_complete", rc_cnt - rc0, 12);
    rnd_ready = 1'b0;

    // Reset at beat 30 discards the partial row.
    mon_en = 1'b0;
    rc0 = rc_cnt;
    fill_row(B);
    send_row(B, 30, 1'b0);
    check("busy_mid_row", busy, 1);
    do_reset();
    check("no_rc_for_partial", rc_cnt - rc0, 0);
    fill_row(B);
    model_row(B);
    send_row(B, B, 1'b0);
    wait_drain();
    check("full_after_reset_rc", rc_cnt - rc0, 1);
    check("full_after_reset_rows", rows_received, 1);

    // Clear on the same edge as the row-ending increment wins.
    fill_row(10);
    model_row(10);
    send_row(10, 10, 1'b1);
    exp_rows = 0; exp_short = 0; exp_long = 0;
    wait_drain();
    check("clear_wins_rows", rows_received, 0);
    check("clear_wins_short", short_errs, 0);
    fill_row(B);
    model_row(B);
    send_row(B, B, 1'b0);
    wait_drain();
    check("after_clear_rows", rows_received, 1);
    check("after_clear_short", short_errs, 0);

`ifdef ROW_SEQ_CHECK_EN
    begin
      logic [31:0] hdr [4];
      int unsigned exp_seq [4];
      hdr[0] = 32'hC008; hdr[1] = 32'hC009; hdr[2] = 32'hC00B; hdr[3] = 32'hC00C;
      exp_seq[0] = 0; exp_seq[1] = 0; exp_seq[2] = 1; exp_seq[3] = 1;
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      check("seq_after_clear", seq_errs, 0);
      for (int unsigned k = 0; k < 4; k++) begin
        fill_row(B);
        row_buf[0][39:8] = hdr[k];
        model_row(B);
        send_row(B, B, 1'b0);
        wait_drain();
        check($sformatf("seq_errs_row%0d", k), seq_errs, exp_seq[k]);
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
